// File: rtl/from_hex.sv
// ---------------------------------------------------------------------------
// from_hex
//   Turns a stream of ASCII hex characters into bytes. Characters are paired
//   high nibble first. Finished bytes go into a small FIFO, and from there
//   they are passed one at a time to a transmitter that uses a strobe
//   handshake.
//
// Ports
//   clk       in   single clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   rx_data   in   [7:0] received ASCII character
//   rx_rdy    in   one-cycle strobe, rx_data valid in that cycle
//   tx_rdy    in   one-cycle strobe, transmitter finished the last byte
//   tx_data   out  [7:0] byte for the transmitter (held between sends)
//   tx_en     out  one-cycle send strobe
//   char_err  out  one-cycle pulse: illegal character or dangling nibble
//   ovf_err   out  one-cycle pulse: decoded byte dropped, queue full
//
// Parameter
//   FIFO_DEPTH  queue depth, power of two from 2 to 16
// ---------------------------------------------------------------------------
module from_hex #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_rdy,
    input  logic       tx_rdy,
    output logic [7:0] tx_data,
    output logic       tx_en,
    output logic       char_err,
    output logic       ovf_err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    typedef enum logic {
        HI,
        LO
    } state_t;

    state_t        state, state_d;
    logic [3:0]    nibble, nibble_d;
    logic [3:0]    digit;
    logic          is_hex, is_sep;
    logic          push_req, push_ok, pop, full_eff;
    logic          char_err_d, ovf_err_d;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          busy;

    // Sort the incoming character into a class and work out its nibble value.
    // For A-F and a-f, the low four bits are 1..6, so adding 9 gives 10..15.
    always_comb begin
        is_hex = 1'b0;
        is_sep = 1'b0;
        digit  = '0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            is_hex = 1'b1;
            digit  = rx_data[3:0];
        end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                     (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
            is_hex = 1'b1;
            digit  = rx_data[3:0] + 4'd9;
        end else if (rx_data == 8'h20 || rx_data == 8'h0D || rx_data == 8'h0A) begin
            is_sep = 1'b1;
        end
    end

    // Nibble-pairing FSM: next state and the requests it makes
    always_comb begin
        state_d    = state;
        nibble_d   = nibble;
        push_req   = 1'b0;
        char_err_d = 1'b0;
        if (rx_rdy) begin
            unique case (state)
                HI: begin
                    if (is_hex) begin
                        nibble_d = digit;
                        state_d  = LO;
                    end else if (!is_sep) begin
                        char_err_d = 1'b1;
                    end
                end
                LO: begin
                    state_d = HI;
                    if (is_hex) begin
                        push_req = 1'b1;
                    end else begin
                        char_err_d = 1'b1;
                    end
                end
                default: state_d = HI;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= HI;
            nibble <= '0;
        end else begin
            state  <= state_d;
            nibble <= nibble_d;
        end
    end

    // "Full" is judged after this cycle's pop, so a full queue that pops
    // and pushes in the same cycle still accepts the new byte.
    assign pop       = !busy && (count != '0);
    assign full_eff  = (count == CNT_FULL) && !pop;
    assign push_ok   = push_req && !full_eff;
    assign ovf_err_d = push_req && full_eff;

    // The queue storage has no reset. Only the pointers and the count define
    // what is valid. When the queue is full and pushes and pops in the same
    // cycle, both pointers address the same entry. The pop reads the old
    // value before the push overwrites it.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {nibble, digit};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            busy     <= 1'b0;
            tx_data  <= '0;
            tx_en    <= 1'b0;
            char_err <= 1'b0;
            ovf_err  <= 1'b0;
        end else begin
            char_err <= char_err_d;
            ovf_err  <= ovf_err_d;
            tx_en    <= pop;

            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end

            if (pop) begin
                tx_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + PTR_ONE;
            end

            unique case ({push_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase

            // pop requires busy=0, and tx_rdy only clears an already-set
            // busy, so the two assignments below never conflict.
            if (pop) begin
                busy <= 1'b1;
            end else if (busy && tx_rdy) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_from_hex.sv
module tb_from_hex;

    localparam int DEPTH = 4;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_rdy  = 1'b0;
    logic       tx_rdy  = 1'b0;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       char_err;
    logic       ovf_err;

    int vecs = 0;
    int errs = 0;

    bit auto_ack = 1'b0;
    bit man_ack  = 1'b0;

    from_hex #(.FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_rdy   (rx_rdy),
        .tx_rdy   (tx_rdy),
        .tx_data  (tx_data),
        .tx_en    (tx_en),
        .char_err (char_err),
        .ovf_err  (ovf_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Reference model
    byte unsigned mq[$];      // decoded bytes waiting to be sent
    byte unsigned sb[$];      // bytes expected on tx_en, oldest first
    bit           m_busy = 1'b0;
    int           m_pend = -1; // pending high nibble, -1 when none
    logic [7:0]   e_data = 8'h00;
    logic         e_en   = 1'b0;
    logic         e_char = 1'b0;
    logic         e_ovf  = 1'b0;

    // Returns 0..15 for a hex digit, -2 for a separator, -1 for anything else
    function automatic int hexval(input logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "A" && c <= "F") return int'(c) - 55;
        if (c >= "a" && c <= "f") return int'(c) - 87;
        if (c == 8'h20 || c == 8'h0D || c == 8'h0A) return -2;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int v;
        bit do_pop;
        byte unsigned b;
        if (!rst_n) begin
            mq.delete();
            sb.delete();
            m_busy = 1'b0;
            m_pend = -1;
            e_data = 8'h00;
            e_en   = 1'b0;
            e_char = 1'b0;
            e_ovf  = 1'b0;
        end else begin
            e_en   = 1'b0;
            e_char = 1'b0;
            e_ovf  = 1'b0;
            do_pop = !m_busy && (mq.size() > 0);
            if (m_busy && tx_rdy) m_busy = 1'b0;
            if (do_pop) begin
                b      = mq.pop_front();
                e_data = b;
                e_en   = 1'b1;
                sb.push_back(b);
                m_busy = 1'b1;
            end
            if (rx_rdy) begin
                v = hexval(rx_data);
                if (m_pend < 0) begin
                    if (v >= 0) m_pend = v;
                    else if (v == -1) e_char = 1'b1;
                end else begin
                    if (v >= 0) begin
                        b = byte'(m_pend * 16 + v);
                        if (mq.size() < DEPTH) mq.push_back(b);
                        else e_ovf = 1'b1;
                    end else begin
                        e_char = 1'b1;
                    end
                    m_pend = -1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor
    always @(negedge clk) begin : monitor
        byte unsigned b;
        chk("tx_en", {7'd0, tx_en}, {7'd0, e_en});
        chk("char_err", {7'd0, char_err}, {7'd0, e_char});
        chk("ovf_err", {7'd0, ovf_err}, {7'd0, e_ovf});
        chk("tx_data_hold", tx_data, e_data);
        if (tx_en === 1'b1) begin
            if (sb.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL tx_byte got %h required none at %0t", tx_data, $time);
            end else begin
                b = sb.pop_front();
                chk("tx_byte", tx_data, b);
            end
        end
    end

    // tx_rdy driver
    initial begin
        forever begin
            @(negedge clk);
            #1;
            tx_rdy = auto_ack ? ($urandom_range(0, 2) == 0) : man_ack;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] c);
        @(negedge clk);
        rx_data = c;
        rx_rdy  = 1'b1;
        @(negedge clk);
        rx_rdy  = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        idle(3);
    endtask

    // High nibble together with a tx_rdy pulse, then low nibble on the next
    // cycle, so the low-nibble push coincides with a pop.
    task automatic pair_ack(input logic [7:0] hi, input logic [7:0] lo);
        @(negedge clk);
        rx_data = hi;
        rx_rdy  = 1'b1;
        man_ack = 1'b1;
        @(negedge clk);
        rx_data = lo;
        man_ack = 1'b0;
        @(negedge clk);
        rx_rdy  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n   = 1'b0;
        rx_data = "5";
        rx_rdy  = 1'b1;
        man_ack = 1'b1;
        idle(3);
        rx_rdy  = 1'b0;
        man_ack = 1'b0;
        #2;
        rst_n   = 1'b1;
    endtask

    function automatic logic [7:0] rand_char();
        string hexs = "0123456789abcdefABCDEF";
        int r = $urandom_range(0, 19);
        if (r < 14) return hexs[$urandom_range(0, 21)];
        if (r == 14) return 8'h20;
        if (r == 15) return 8'h0D;
        if (r == 16) return 8'h0A;
        return 8'($urandom);
    endfunction

    initial begin
        idle(3);
        #2;
        rst_n = 1'b1;
        idle(2);

        // Single byte, then acknowledge
        send_str("41");
        idle(3);
        pulse_ack();

        // Separator between bytes; the second send waits for tx_rdy
        send_str("fF 0a");
        idle(4);
        pulse_ack();
        idle(4);
        pulse_ack();

        // Illegal character in the high-nibble position
        send_str("3G7e");
        idle(3);
        pulse_ack();

        // Fill the queue with the transmitter stalled, then overflow it
        send_str("000102030405");
        idle(3);
        // Queue full, pop and push in the same cycle
        pair_ack("0", "6");
        idle(2);
        repeat (7) pulse_ack();

        // Reset mid-operation discards the pending nibble
        send("9");
        do_reset();
        send_str("2B");
        idle(3);
        pulse_ack();

        // Random traffic, sometimes with the transmitter stalled
        for (int blk = 0; blk < 8; blk++) begin
            auto_ack = (blk % 3) != 2;
            for (int i = 0; i < 80; i++) begin
                send(rand_char());
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        do_reset();
        auto_ack = 1'b1;
        for (int i = 0; i < 80; i++) send(rand_char());

        // Drain
        idle(150);
        vecs++;
        if (sb.size() != 0) begin
            errs++;
            $display("FAIL drain got %0d pending required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
